pwm_moving_avg: RTL and testbench

PWM_MOVING_AVG -- requirements
Module: pwm_moving_avg

---
 rtl/pwm_moving_avg.sv | 81 ++++++++
 tb/tb_pwm_moving_avg.sv | 128 ++++++++++++
 2 files changed

// File: rtl/pwm_moving_avg.sv
// Boxcar moving-average filter for a 1-bit PWM stream: a WIN-deep delay line,
// a running sum of ones in the window, and the window average in percent.
module pwm_moving_avg #(
   parameter int WIN = 512,
   parameter int SW  = $clog2(WIN) + 1
) (
   input  logic          clk_main,
   input  logic          rst,
   input  logic          ce,
   input  logic          duty,
   output logic [SW-1:0] sum,
   output logic [6:0]    level,
   output logic          valid
);

   localparam int LW = $clog2(WIN);
   localparam int PW = SW + 7;

   typedef enum logic {FILL, RUN} state_t;

   state_t         state, state_next;
   logic [WIN-1:0] line;
   logic [LW-1:0]  fill_cnt, fill_cnt_next;
   logic           valid_next;
   logic           old;
   logic [SW-1:0]  sum_next;
   logic [6:0]     level_next;

   // old=1 implies sum>=1 and a full all-ones window forces old=1, so this
   // never leaves 0..WIN.
   assign old      = line[WIN-1];
   assign sum_next = sum + SW'(duty) - SW'(old);

   // sum*100 needs 7 bits above SW; the >>LW divides by the window length.
   assign level_next = 7'((PW'(sum_next) * PW'(100)) >> LW);

   always_comb begin
      state_next    = state;
      fill_cnt_next = fill_cnt;
      valid_next    = valid;
      case (state)
         FILL: begin
            if (ce) begin
               if (fill_cnt == LW'(WIN - 1)) begin
                  state_next = RUN;
                  valid_next = 1'b1;
               end else begin
                  fill_cnt_next = fill_cnt + 1'b1;
               end
            end
         end
         RUN: begin
            valid_next = 1'b1;
         end
         default: begin
            state_next = FILL;
         end
      endcase
   end

   always_ff @(posedge clk_main or posedge rst) begin
      if (rst) begin
         state    <= FILL;
         fill_cnt <= '0;
         valid    <= 1'b0;
         line     <= '0;
         sum      <= '0;
         level    <= '0;
      end else begin
         state    <= state_next;
         fill_cnt <= fill_cnt_next;
         valid    <= valid_next;
         if (ce) begin
            line  <= {line[WIN-2:0], duty};
            sum   <= sum_next;
            level <= level_next;
         end
      end
   end

endmodule

// File: tb/tb_pwm_moving_avg.sv
// Directed-vector bench: WIN=8 instance driven from a table plus a mid-run
// reset sequence, and a WIN=512 instance fed a 25% PWM.
module tb_pwm_moving_avg;

   logic       clk;
   logic       rst_a, ce_a, duty_a;
   logic [3:0] sum_a;
   logic [6:0] level_a;
   logic       valid_a;

   logic       rst_b, ce_b, duty_b;
   logic [9:0] sum_b;
   logic [6:0] level_b;
   logic       valid_b;

   int n_vec = 0;
   int n_bad = 0;

   pwm_moving_avg #(.WIN(8)) dut_a (
      .clk_main(clk), .rst(rst_a), .ce(ce_a), .duty(duty_a),
      .sum(sum_a), .level(level_a), .valid(valid_a)
   );

   pwm_moving_avg #(.WIN(512)) dut_b (
      .clk_main(clk), .rst(rst_b), .ce(ce_b), .duty(duty_b),
      .sum(sum_b), .level(level_b), .valid(valid_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit rst;
      bit ce;
      bit duty;
      int sum;
      bit valid;
   } vec_t;

   vec_t vt[$];
   int   lvl_tab [0:8] = '{0, 12, 25, 37, 50, 62, 75, 87, 100};

   task automatic add(input bit r, input bit c, input bit d, input int s, input bit v);
      vec_t t;
      t.rst = r; t.ce = c; t.duty = d; t.sum = s; t.valid = v;
      vt.push_back(t);
   endtask

   task automatic chk(input string nm, input int idx, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s #%0d: got %0d want %0d", nm, idx, act, exp);
      end
   endtask

   task automatic apply_a(input vec_t v, input int idx);
      @(negedge clk);
      rst_a = v.rst; ce_a = v.ce; duty_a = v.duty;
      @(posedge clk);
      #1;
      chk("sum", idx, int'(sum_a), v.sum);
      chk("level", idx, int'(level_a), lvl_tab[v.sum]);
      chk("valid", idx, int'(valid_a), int'(v.valid));
   endtask

   initial begin
      vec_t v;
      rst_a = 1'b1; ce_a = 1'b0; duty_a = 1'b0;
      rst_b = 1'b1; ce_b = 1'b0; duty_b = 1'b0;

      // reset with coincident ce=1 must be ignored
      add(1, 1, 1, 0, 0);
      // step fill, then a hold edge, then falling step
      for (int i = 1; i <= 8; i++) add(0, 1, 1, i, i == 8);
      add(0, 0, 0, 8, 1);
      for (int i = 7; i >= 0; i--) add(0, 1, 0, i, 1);
      // 50% pattern 1,1,0,0
      add(1, 0, 0, 0, 0);
      begin
         int ps [0:7] = '{1, 2, 2, 2, 3, 4, 4, 4};
         for (int i = 0; i < 8; i++) add(0, 1, (i % 4) < 2, ps[i], i == 7);
         for (int i = 8; i < 16; i++) add(0, 1, (i % 4) < 2, 4, 1);
      end
      // enable gating: ce toggles 1,0,...
      add(1, 0, 0, 0, 0);
      for (int i = 0; i < 16; i++) add(0, (i % 2) == 0, 1, i / 2 + 1, i >= 14);

      for (int i = 0; i < vt.size(); i++) apply_a(vt[i], i);

      // mid-run reset: reach sum=5 in RUN, then reset away from any edge
      v.ce = 1'b1; v.rst = 1'b0;
      apply_a('{1, 0, 0, 0, 0}, 100);
      for (int i = 1; i <= 8; i++) apply_a('{0, 1, 1, i, i == 8}, 100 + i);
      for (int i = 7; i >= 5; i--) apply_a('{0, 1, 0, i, 1}, 120 - i);
      @(negedge clk);
      ce_a = 1'b0;
      #2 rst_a = 1'b1;
      #1;
      chk("async_sum", 200, int'(sum_a), 0);
      chk("async_level", 200, int'(level_a), 0);
      chk("async_valid", 200, int'(valid_a), 0);
      @(negedge clk);
      rst_a = 1'b0;
      apply_a('{0, 0, 1, 0, 0}, 210);
      for (int i = 1; i <= 8; i++) apply_a('{0, 1, 1, i, i == 8}, 210 + i);

      // WIN=512: period-512 PWM with 128 high cycles
      @(negedge clk);
      rst_b = 1'b0; ce_b = 1'b1;
      for (int t = 0; t < 1200; t++) begin
         duty_b = (t % 512) < 128;
         @(posedge clk);
         #1;
         if (t == 510) chk("w512_valid_early", t, int'(valid_b), 0);
         if (t >= 511) begin
            chk("w512_sum", t, int'(sum_b), 128);
            chk("w512_level", t, int'(level_b), 25);
            chk("w512_valid", t, int'(valid_b), 1);
         end
         @(negedge clk);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
